// File: rtl/hazard_pkg.sv
// Shared register-file constants for the pipeline hazard logic.
package hazard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/sb_popcount.sv
// Combinational population count of the scoreboard pending vector.
module sb_popcount #(
  parameter int N = 32
) (
  input  logic [N-1:0] vec,
  output logic [5:0]   cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + 6'(vec[i]);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-pending scoreboard beside ID: stalls RAW/WAW hazards and drives PC/IF-ID hold and ID/EX bubble.
// Build option HAZARD_SB_FWD_EN: ALU results are forwarded, so only load producers cause stalls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG  = NUM_REGS,
  parameter int AW    = REG_ADDR_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rs,
  input  logic [AW-1:0]    issue_rt,
  input  logic             issue_use_rs,
  input  logic             issue_use_rt,
  input  logic             issue_wr_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic             issue_is_load,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  output logic             stall,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             bubble,
  output logic [5:0]       pending_cnt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err_wb
);

  logic [NREG-1:0]  pend_q, pend_d;
  logic [NREG-1:0]  ld_q, ld_d;
  logic [NREG-1:0]  wb_mask, eff, haz_vec;
  logic [5:0]       pending_cnt_q, pending_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             err_wb_q, err_wb_d;
  logic             raw, waw, fire, rd_nz, wb_nz;

  assign rd_nz = issue_rd != '0;
  assign wb_nz = wb_rd != '0;

  // A writeback this cycle releases its register before the hazard check.
  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_rd] = 1'b1;
  end

  assign eff = pend_q & ~wb_mask;

`ifdef HAZARD_SB_FWD_EN
  assign haz_vec = eff & ld_q;
`else
  assign haz_vec = eff;
`endif

  assign raw   = (issue_use_rs & haz_vec[issue_rs]) | (issue_use_rt & haz_vec[issue_rt]);
  assign waw   = issue_wr_en & rd_nz & haz_vec[issue_rd];
  assign stall = issue_valid & (raw | waw) & ~rst;
  assign fire  = issue_valid & ~stall;

  assign en_pc   = ~stall;
  assign en_ifid = ~stall;
  assign bubble  = stall;

  // Clear on writeback first so a same-cycle issue to that register wins.
  always_comb begin
    pend_d = pend_q;
    ld_d   = ld_q;
    if (wb_valid) begin
      pend_d[wb_rd] = 1'b0;
      ld_d[wb_rd]   = 1'b0;
    end
    if (fire && issue_wr_en && rd_nz) begin
      pend_d[issue_rd] = 1'b1;
      ld_d[issue_rd]   = issue_is_load;
    end
    pend_d[0] = 1'b0;
    ld_d[0]   = 1'b0;

    err_wb_d = err_wb_q | (wb_valid & wb_nz & ~pend_q[wb_rd]);

    stall_cycles_d = stall_cycles_q;
    if (stall && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  sb_popcount #(.N(NREG)) u_popcount (
    .vec (pend_d),
    .cnt (pending_cnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q         <= '0;
      ld_q           <= '0;
      pending_cnt_q  <= '0;
      stall_cycles_q <= '0;
      err_wb_q       <= 1'b0;
    end else begin
      pend_q         <= pend_d;
      ld_q           <= ld_d;
      pending_cnt_q  <= pending_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      err_wb_q       <= err_wb_d;
    end
  end

  assign pending_cnt  = pending_cnt_q;
  assign stall_cycles = stall_cycles_q;
  assign err_wb       = err_wb_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic against a register-level model.
module tb_hazard_scoreboard;

`ifdef HAZARD_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_use_rs, issue_use_rt, issue_wr_en, issue_is_load, wb_valid;
  logic [4:0]  issue_rs, issue_rt, issue_rd, wb_rd;
  logic        stall, en_pc, en_ifid, bubble, err_wb;
  logic [5:0]  pending_cnt;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_pend[32];
  bit m_ld[32];
  bit m_err;
  int m_cyc;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_use_rs (issue_use_rs),
    .issue_use_rt (issue_use_rt),
    .issue_wr_en  (issue_wr_en),
    .issue_rd     (issue_rd),
    .issue_is_load(issue_is_load),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .stall        (stall),
    .en_pc        (en_pc),
    .en_ifid      (en_ifid),
    .bubble       (bubble),
    .pending_cnt  (pending_cnt),
    .stall_cycles (stall_cycles),
    .err_wb       (err_wb)
  );

  always #5 clk = ~clk;

  // Is register r a hazard for the instruction now in ID?
  function automatic bit m_hazard(input int r);
    bit busy;
    if (r == 0) return 1'b0;
    busy = m_pend[r] && !(wb_valid && int'(wb_rd) == r);
    return FWD ? (busy && m_ld[r]) : busy;
  endfunction

  function automatic bit m_stall();
    bit h;
    h = (issue_use_rs && m_hazard(int'(issue_rs))) ||
        (issue_use_rt && m_hazard(int'(issue_rt))) ||
        (issue_wr_en && m_hazard(int'(issue_rd)));
    return issue_valid && h;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_pend[r]);
    return c;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_pend[r] = 1'b0;
      m_ld[r]   = 1'b0;
    end
    m_err = 1'b0;
    m_cyc = 0;
  endtask

  task automatic model_step();
    bit st;
    st = m_stall();
    if (st && m_cyc < 65535) m_cyc++;
    if (wb_valid && wb_rd != 0 && !m_pend[wb_rd]) m_err = 1'b1;
    if (wb_valid) begin
      m_pend[wb_rd] = 1'b0;
      m_ld[wb_rd]   = 1'b0;
    end
    if (issue_valid && !st && issue_wr_en && issue_rd != 0) begin
      m_pend[issue_rd] = 1'b1;
      m_ld[issue_rd]   = issue_is_load;
    end
  endtask

  // Advance one clock, keeping the model in step; returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_use_rs = 0; issue_use_rt = 0; issue_wr_en = 0; issue_is_load = 0;
    issue_rs = 0; issue_rt = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic set_issue(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                           input bit wr, input int rd, input bit ld);
    issue_valid = v; issue_rs = 5'(rs); issue_use_rs = urs; issue_rt = 5'(rt); issue_use_rt = urt;
    issue_wr_en = wr; issue_rd = 5'(rd); issue_is_load = ld;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    set_issue(1, 1, 1, 2, 1, 1, 3, 0);
    #1;
    n_checks++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall got %b exp 0", stall); else n_pass++;
    n_checks++; if ({en_pc, en_ifid, bubble} !== 3'b110) $display("[TB] FAIL reset_ctrl got %b exp 110", {en_pc, en_ifid, bubble}); else n_pass++;
    n_checks++; if ({pending_cnt, stall_cycles, err_wb} !== 23'd0) $display("[TB] FAIL reset_regs got cnt=%0d cyc=%0d err=%b exp 0", pending_cnt, stall_cycles, err_wb); else n_pass++;
    do_reset();
  endtask

  task automatic test_alu_raw();
    bit exp_st;
    do_reset();
    set_issue(1, 0, 0, 0, 0, 1, 5, 0);
    tick();
    n_checks++; if (pending_cnt !== 6'd1) $display("[TB] FAIL alu_cnt got %0d exp 1", pending_cnt); else n_pass++;
    set_issue(1, 5, 1, 0, 0, 0, 0, 0);
    #1;
    exp_st = !FWD;
    n_checks++; if (stall !== exp_st) $display("[TB] FAIL alu_raw_stall got %b exp %b", stall, exp_st); else n_pass++;
    n_checks++; if ({en_pc, en_ifid, bubble} !== {!exp_st, !exp_st, exp_st}) $display("[TB] FAIL alu_raw_ctrl got %b exp %b", {en_pc, en_ifid, bubble}, {!exp_st, !exp_st, exp_st}); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_issue(1, 0, 0, 0, 0, 1, 8, 1);
    tick();
    set_issue(1, 0, 0, 8, 1, 0, 0, 0);
    #1;
    n_checks++; if (stall !== 1'b1) $display("[TB] FAIL load_use_stall got %b exp 1", stall); else n_pass++;
    n_checks++; if (bubble !== 1'b1 || en_pc !== 1'b0) $display("[TB] FAIL load_use_ctrl got bubble=%b en_pc=%b exp 1/0", bubble, en_pc); else n_pass++;
    wb_valid = 1; wb_rd = 8;
    #1;
    n_checks++; if (stall !== 1'b0) $display("[TB] FAIL load_wb_bypass got %b exp 0", stall); else n_pass++;
    tick();
    idle_inputs();
    n_checks++; if (pending_cnt !== 6'd0 || err_wb !== 1'b0) $display("[TB] FAIL load_wb_after got cnt=%0d err=%b exp 0/0", pending_cnt, err_wb); else n_pass++;
  endtask

  task automatic test_issue_wb_same();
    do_reset();
    set_issue(1, 0, 0, 0, 0, 1, 3, 0);
    tick();
    set_issue(1, 0, 0, 0, 0, 1, 3, 0);
    wb_valid = 1; wb_rd = 3;
    #1;
    n_checks++; if (stall !== 1'b0) $display("[TB] FAIL same_cycle_stall got %b exp 0", stall); else n_pass++;
    tick();
    idle_inputs();
    n_checks++; if (pending_cnt !== 6'd1 || err_wb !== 1'b0) $display("[TB] FAIL same_cycle_cnt got cnt=%0d err=%b exp 1/0", pending_cnt, err_wb); else n_pass++;
    set_issue(1, 3, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (stall !== !FWD) $display("[TB] FAIL same_cycle_pend got %b exp %b", stall, !FWD); else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_reg0();
    do_reset();
    set_issue(1, 0, 0, 0, 0, 1, 0, 1);
    tick();
    n_checks++; if (pending_cnt !== 6'd0) $display("[TB] FAIL reg0_cnt got %0d exp 0", pending_cnt); else n_pass++;
    set_issue(1, 0, 1, 0, 1, 1, 0, 1);
    #1;
    n_checks++; if (stall !== 1'b0) $display("[TB] FAIL reg0_stall got %b exp 0", stall); else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_err_wb();
    do_reset();
    wb_valid = 1; wb_rd = 12;
    tick();
    idle_inputs();
    n_checks++; if (err_wb !== 1'b1) $display("[TB] FAIL err_set got %b exp 1", err_wb); else n_pass++;
    set_issue(1, 0, 0, 0, 0, 1, 12, 0);
    tick();
    wb_valid = 1; wb_rd = 12; issue_valid = 0;
    repeat (3) tick();
    n_checks++; if (err_wb !== 1'b1) $display("[TB] FAIL err_sticky got %b exp 1", err_wb); else n_pass++;
    do_reset();
    #1;
    n_checks++; if (err_wb !== 1'b0) $display("[TB] FAIL err_clear got %b exp 0", err_wb); else n_pass++;
  endtask

  task automatic test_random();
    int q[$];
    int errs = 0;
    bit exp_st;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1));
      q.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) q.push_back(r);
      wb_valid = $urandom_range(0, 9) < 4;
      if (q.size() > 0 && $urandom_range(0, 9) != 0) wb_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
      else wb_rd = 5'($urandom_range(0, 31));
      #1;
      exp_st = m_stall();
      if (stall !== exp_st || bubble !== exp_st || en_pc !== !exp_st || en_ifid !== !exp_st) begin
        if (errs < 5) $display("[TB] FAIL rand_stall cycle %0d got %b exp %b", i, stall, exp_st);
        errs++;
      end
      tick();
      if (pending_cnt !== 6'(m_count()) || err_wb !== m_err || stall_cycles !== 16'(m_cyc)) begin
        if (errs < 5) $display("[TB] FAIL rand_state cycle %0d got cnt=%0d err=%b cyc=%0d exp cnt=%0d err=%b cyc=%0d",
                               i, pending_cnt, err_wb, stall_cycles, m_count(), m_err, m_cyc);
        errs++;
      end
    end
    idle_inputs();
    n_checks++; if (errs != 0) $display("[TB] FAIL rand_total got %0d mismatching cycles exp 0", errs); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    set_issue(1, 0, 0, 0, 0, 1, 9, 1);
    tick();
    set_issue(1, 9, 1, 0, 0, 0, 0, 0);
    repeat (70000) tick();
    n_checks++; if (stall_cycles !== 16'hFFFF) $display("[TB] FAIL sat_cycles got %h exp ffff", stall_cycles); else n_pass++;
    n_checks++; if (stall !== 1'b1 || pending_cnt !== 6'd1) $display("[TB] FAIL sat_hold got stall=%b cnt=%0d exp 1/1", stall, pending_cnt); else n_pass++;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if ({stall, bubble, en_pc, en_ifid} !== 4'b0011) $display("[TB] FAIL rst_mid_ctrl got %b exp 0011", {stall, bubble, en_pc, en_ifid}); else n_pass++;
    n_checks++; if ({pending_cnt, stall_cycles, err_wb} !== 23'd0) $display("[TB] FAIL rst_mid_regs got cnt=%0d cyc=%0d err=%b exp 0", pending_cnt, stall_cycles, err_wb); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("[TB] FAIL rst_release got %b exp 0", stall); else n_pass++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    test_reset();
    test_alu_raw();
    test_load_use();
    test_issue_wb_same();
    test_reg0();
    test_err_wb();
    test_random();
    test_saturation();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
